// File: rtl/sticky_status_reader.sv
// Sticky status capture with overflow tracking and an atomic read-and-clear snapshot
// returned over a valid/ready request/response pair.
module sticky_status_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     evt_in,
    input  logic [WIDTH-1:0]     evt_mask,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_status,
    output logic [WIDTH-1:0]     rsp_ovfl,
    output logic [CNT_WIDTH-1:0] rsp_lost_cnt,
    output logic [WIDTH-1:0]     status_live,
    output logic                 irq
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     status_q, status_d;
    logic [WIDTH-1:0]     ovfl_q, ovfl_d;
    logic [CNT_WIDTH-1:0] lost_q, lost_d;
    logic [WIDTH-1:0]     rsp_status_q, rsp_status_d;
    logic [WIDTH-1:0]     rsp_ovfl_q, rsp_ovfl_d;
    logic [CNT_WIDTH-1:0] rsp_lost_q, rsp_lost_d;

    logic [WIDTH-1:0]     evt_eff;
    logic [WIDTH-1:0]     hit;

    assign evt_eff = evt_in & evt_mask;
    assign hit     = evt_eff & status_q;

    always_comb begin
        state_d      = state_q;
        status_d     = status_q | evt_eff;
        ovfl_d       = ovfl_q | hit;
        lost_d       = lost_q;
        rsp_status_d = rsp_status_q;
        rsp_ovfl_d   = rsp_ovfl_q;
        rsp_lost_d   = rsp_lost_q;
        if ((|hit) && (lost_q != {CNT_WIDTH{1'b1}}))
            lost_d = lost_q + CNT_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Snapshot takes pre-update state; same-cycle events seed the fresh status.
                    rsp_status_d = status_q;
                    rsp_ovfl_d   = ovfl_q;
                    rsp_lost_d   = lost_q;
                    status_d     = evt_eff;
                    ovfl_d       = '0;
                    lost_d       = '0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            status_q     <= '0;
            ovfl_q       <= '0;
            lost_q       <= '0;
            rsp_status_q <= '0;
            rsp_ovfl_q   <= '0;
            rsp_lost_q   <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            ovfl_q       <= ovfl_d;
            lost_q       <= lost_d;
            rsp_status_q <= rsp_status_d;
            rsp_ovfl_q   <= rsp_ovfl_d;
            rsp_lost_q   <= rsp_lost_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_status   = rsp_status_q;
    assign rsp_ovfl     = rsp_ovfl_q;
    assign rsp_lost_cnt = rsp_lost_q;
    assign status_live  = status_q;
    // Driven from registers only, so no combinational path from evt_in to irq.
    assign irq          = |status_q;

endmodule

// File: tb/tb_sticky_status_reader.sv
// Bench for sticky_status_reader: directed vector table, hand corner sequences,
// and randomized traffic against a per-bit event-count reference model.
module tb_sticky_status_reader;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  evt_in, evt_mask;
    logic          req_valid, rsp_ready;
    logic          req_ready, rsp_valid, irq;
    logic [W-1:0]  rsp_status, rsp_ovfl, status_live;
    logic [CW-1:0] rsp_lost_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sticky_status_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .evt_mask(evt_mask),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_ovfl(rsp_ovfl), .rsp_lost_cnt(rsp_lost_cnt),
        .status_live(status_live), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, clock once, land back on negedge for sampling.
    task automatic step(input logic [W-1:0] e, input logic [W-1:0] m,
                        input logic rv, input logic rr);
        evt_in = e; evt_mask = m; req_valid = rv; rsp_ready = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int sl, input int v,
                           input int rs, input int ro, input int rl);
        chk({tag, ".status_live"}, status_live, sl);
        chk({tag, ".irq"}, irq, (sl != 0) ? 1 : 0);
        chk({tag, ".rsp_valid"}, rsp_valid, v);
        chk({tag, ".req_ready"}, req_ready, v ? 0 : 1);
        chk({tag, ".rsp_status"}, rsp_status, rs);
        chk({tag, ".rsp_ovfl"}, rsp_ovfl, ro);
        chk({tag, ".rsp_lost_cnt"}, rsp_lost_cnt, rl);
    endtask

    typedef struct {
        logic [W-1:0] e, m;
        logic rv, rr;
        int sl, v, rs, ro, rl;
    } vec_t;

    // Reference model: per-bit count of accepted events since the last read,
    // plus an unbounded count of cycles that repeated an already-set bit.
    int m_cnt[W];
    int m_lost;
    bit m_pend;
    int m_rs, m_ro, m_rl;

    function automatic int mdl_status();
        int s = 0;
        for (int i = 0; i < W; i++) if (m_cnt[i] > 0) s |= (1 << i);
        return s;
    endfunction

    function automatic int mdl_ovfl();
        int s = 0;
        for (int i = 0; i < W; i++) if (m_cnt[i] > 1) s |= (1 << i);
        return s;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
        m_lost = 0; m_pend = 0; m_rs = 0; m_ro = 0; m_rl = 0;
    endfunction

    function automatic void mdl_cycle(input logic [W-1:0] e, input logic [W-1:0] m,
                                      input logic rv, input logic rr);
        logic [W-1:0] eff = e & m;
        if (!m_pend && rv) begin
            m_rs = mdl_status(); m_ro = mdl_ovfl();
            m_rl = (m_lost > SAT) ? SAT : m_lost;
            for (int i = 0; i < W; i++) m_cnt[i] = eff[i] ? 1 : 0;
            m_lost = 0;
            m_pend = 1;
        end else begin
            bit repeat_seen = 0;
            for (int i = 0; i < W; i++) if (eff[i]) begin
                if (m_cnt[i] > 0) repeat_seen = 1;
                m_cnt[i]++;
            end
            if (repeat_seen) m_lost++;
            if (m_pend && rr) m_pend = 0;
        end
    endfunction

    vec_t tbl[$];

    initial begin
        logic [W-1:0] held_rs;
        bit done;
        rst = 1'b1; evt_in = '0; evt_mask = '1; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0);

        //          e      m      rv rr  sl    v  rs    ro    rl
        tbl.push_back('{8'h05, 8'hFF, 0, 0, 8'h05, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{8'h00, 8'hFF, 1, 0, 8'h00, 1, 8'h05, 8'h00, 0});
        tbl.push_back('{8'h00, 8'hFF, 0, 1, 8'h00, 0, 8'h05, 8'h00, 0});
        tbl.push_back('{8'h01, 8'hFF, 0, 0, 8'h01, 0, 8'h05, 8'h00, 0});
        tbl.push_back('{8'h01, 8'hFF, 0, 0, 8'h01, 0, 8'h05, 8'h00, 0});
        tbl.push_back('{8'h01, 8'hFF, 0, 0, 8'h01, 0, 8'h05, 8'h00, 0});
        tbl.push_back('{8'h00, 8'hFF, 1, 0, 8'h00, 1, 8'h01, 8'h01, 2});
        tbl.push_back('{8'h00, 8'hFF, 0, 1, 8'h00, 0, 8'h01, 8'h01, 2});
        tbl.push_back('{8'h03, 8'hFF, 0, 0, 8'h03, 0, 8'h01, 8'h01, 2});
        tbl.push_back('{8'h06, 8'hFF, 1, 0, 8'h06, 1, 8'h03, 8'h00, 0});
        tbl.push_back('{8'h80, 8'hFF, 1, 0, 8'h86, 1, 8'h03, 8'h00, 0});
        tbl.push_back('{8'h80, 8'hFF, 0, 0, 8'h86, 1, 8'h03, 8'h00, 0});
        tbl.push_back('{8'h80, 8'hFF, 0, 1, 8'h86, 0, 8'h03, 8'h00, 0});
        tbl.push_back('{8'h04, 8'hFB, 0, 0, 8'h86, 0, 8'h03, 8'h00, 0});
        tbl.push_back('{8'h00, 8'hFF, 1, 0, 8'h00, 1, 8'h86, 8'h80, 2});
        tbl.push_back('{8'h00, 8'hFF, 0, 1, 8'h00, 0, 8'h86, 8'h80, 2});
        foreach (tbl[k]) begin
            step(tbl[k].e, tbl[k].m, tbl[k].rv, tbl[k].rr);
            chk_all($sformatf("vec%0d", k), tbl[k].sl, tbl[k].v, tbl[k].rs, tbl[k].ro, tbl[k].rl);
        end

        // Stall: response held 5 cycles with events on bit 7.
        step(8'h00, 8'hFF, 1, 0);
        held_rs = rsp_status;
        for (int i = 0; i < 5; i++) begin
            step(8'h80, 8'hFF, 1, 0);
            chk("stall.rsp_valid", rsp_valid, 1);
            chk("stall.req_ready", req_ready, 0);
            chk("stall.rsp_status", rsp_status, held_rs);
            chk("stall.status_live", status_live, 8'h80);
        end
        step(8'h00, 8'hFF, 0, 1);
        chk("stall.release", rsp_valid, 0);
        step(8'h00, 8'hFF, 1, 0);
        chk("stall.read_ovfl", rsp_ovfl, 8'h80);
        chk("stall.read_lost", rsp_lost_cnt, 4);
        step(8'h00, 8'hFF, 0, 1);

        // Saturation: 20 events on bit 2 -> 19 repeats, counter pins at all-ones.
        for (int i = 0; i < 20; i++) step(8'h04, 8'hFF, 0, 0);
        step(8'h04, 8'hFB, 0, 0);
        chk("sat.masked_live", status_live, 8'h04);
        step(8'h00, 8'hFF, 1, 0);
        chk("sat.lost", rsp_lost_cnt, SAT);
        chk("sat.ovfl", rsp_ovfl, 8'h04);
        step(8'h00, 8'hFF, 0, 1);

        // Reset while a response is pending.
        step(8'hFF, 8'hFF, 0, 0);
        step(8'h00, 8'hFF, 1, 0);
        chk("rstresp.pending", rsp_valid, 1);
        rst = 1'b1;
        step(8'h00, 8'hFF, 0, 0);
        rst = 1'b0;
        chk_all("rstresp", 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        mdl_reset();
        done = 0;
        for (int c = 0; c < 600; c++) begin
            logic [W-1:0] e, m;
            logic rv, rr;
            e  = W'($urandom) & W'($urandom) & W'($urandom);
            m  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '1;
            if ($urandom_range(0, 9) < 3) e = W'(1 << $urandom_range(0, W-1));
            rv = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 2) != 0);
            step(e, m, rv, rr);
            mdl_cycle(e, m, rv, rr);
            chk_all($sformatf("rnd%0d", c), mdl_status(), m_pend ? 1 : 0, m_rs, m_ro, m_rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
